// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 calculator keypad scanner:
// key ids, frame results, FSM states and the key-to-code map.
package keypad_pkg;

  typedef logic [3:0] key_id_t;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_KEY,
    RES_MULTI
  } frame_res_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_t;

  localparam logic [7:0] KEY_PLUS  = 8'h2B;
  localparam logic [7:0] KEY_MINUS = 8'h2D;
  localparam logic [7:0] KEY_MUL   = 8'h2A;
  localparam logic [7:0] KEY_DIV   = 8'h2F;
  localparam logic [7:0] KEY_EQ    = 8'h3D;
  localparam logic [7:0] KEY_CLR   = 8'h43;

  // Indexed by key id = 4*row + col.
  localparam logic [7:0] KEY_CODES [16] = '{
    8'h01, 8'h02, 8'h03,   8'h04,
    8'h05, 8'h06, 8'h07,   8'h08,
    8'h09, 8'h00, KEY_PLUS, KEY_MINUS,
    KEY_MUL, KEY_DIV, KEY_EQ, KEY_CLR
  };

endpackage

// File: rtl/keypad_if.sv
// Key-code handshake between the keypad scanner and the calculator sequencer.
interface keypad_if;
  logic [7:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       overrun;

  modport master (output key_code, output key_valid, output overrun, input key_ready);
  modport slave  (input key_code, input key_valid, input overrun, output key_ready);
endinterface

// File: rtl/keypad_row_driver.sv
// Row scan timing, column synchronizer and per-frame column accumulation;
// raises frame_stb on the row-3 sample cycle with the frame's result.
module keypad_row_driver
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic       frame_stb,
  output frame_res_t frame_res,
  output key_id_t    frame_id
);

  localparam int DW = $clog2(SCAN_DIV);

  logic [DW-1:0] div;
  logic [1:0]    row;
  logic [1:0]    row_nxt;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [1:0]    acc_cnt;   // low columns seen so far this frame, saturating at 2
  key_id_t       acc_id;
  logic          slot_end;
  logic [2:0]    cur_cnt;
  logic [1:0]    cur_col;
  logic [2:0]    sum;
  key_id_t       merged_id;

  assign slot_end = (div == DW'(SCAN_DIV - 1));
  assign row_nxt  = row + 2'd1;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cur_cnt = '0;
    cur_col = '0;
    for (int c = 0; c < 4; c++) begin
      if (!sync2[c]) begin
        cur_cnt = cur_cnt + 3'd1;
        cur_col = 2'(c);
      end
    end
    sum       = {1'b0, acc_cnt} + cur_cnt;
    merged_id = (cur_cnt != 3'd0) ? {row, cur_col} : acc_id;
  end

  assign frame_stb = slot_end && (row == 2'd3);
  assign frame_id  = merged_id;
  assign frame_res = (sum == 3'd0) ? RES_NONE :
                     (sum == 3'd1) ? RES_KEY  : RES_MULTI;

  // NOTE: reset is synchronous (sampled on the clock edge) and state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div     <= '0;
      row     <= 2'd0;
      row_out <= 4'b1110;
      sync1   <= 4'b1111;
      sync2   <= 4'b1111;
      acc_cnt <= 2'd0;
      acc_id  <= '0;
    end else begin
      sync1 <= col_in;
      sync2 <= sync1;
      if (slot_end) begin
        div     <= '0;
        row     <= row_nxt;
        row_out <= ~(4'b0001 << row_nxt);
        if (row == 2'd3) begin
          acc_cnt <= 2'd0;
          acc_id  <= '0;
        end else begin
          acc_cnt <= (sum > 3'd1) ? 2'd2 : sum[1:0];
          acc_id  <= merged_id;
        end
      end else begin
        div <= div + DW'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: frame-level press/release debounce FSM and the
// single-entry key-code output register with overrun reporting.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  keypad_if.master   kif
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE);

  logic       frame_stb;
  frame_res_t frame_res;
  key_id_t    frame_id;

  state_t        state, state_n;
  key_id_t       cand, cand_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] cnt_inc;
  logic          accept;
  logic          transfer;

  keypad_row_driver #(.SCAN_DIV(SCAN_DIV)) u_rows (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_in    (col_in),
    .row_out   (row_out),
    .frame_stb (frame_stb),
    .frame_res (frame_res),
    .frame_id  (frame_id)
  );

  assign cnt_inc  = cnt + CW'(1);
  assign transfer = kif.key_valid && kif.key_ready;

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    accept  = 1'b0;
    if (frame_stb) begin
      unique case (state)
        ST_IDLE: begin
          if (frame_res == RES_KEY) begin
            cand_n = frame_id;
            if (DEBOUNCE == 1) begin
              accept  = 1'b1;
              state_n = ST_PRESSED;
              cnt_n   = '0;
            end else begin
              state_n = ST_DEBOUNCE;
              cnt_n   = CW'(1);
            end
          end
        end
        ST_DEBOUNCE: begin
          if (frame_res != RES_KEY) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end else if (frame_id != cand) begin
            cand_n = frame_id;
            cnt_n  = CW'(1);
          end else if (cnt_inc == DB_LAST) begin
            accept  = 1'b1;
            state_n = ST_PRESSED;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        ST_PRESSED: begin
          if (frame_res == RES_NONE) begin
            state_n = (DEBOUNCE == 1) ? ST_IDLE : ST_RELEASE;
            cnt_n   = (DEBOUNCE == 1) ? '0 : CW'(1);
          end
        end
        ST_RELEASE: begin
          if (frame_res != RES_NONE) begin
            state_n = ST_PRESSED;
            cnt_n   = '0;
          end else if (cnt_inc == DB_LAST) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cand          <= '0;
      cnt           <= '0;
      kif.key_code  <= 8'h00;
      kif.key_valid <= 1'b0;
      kif.overrun   <= 1'b0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
      if (accept && (!kif.key_valid || transfer)) begin
        kif.key_code  <= KEY_CODES[frame_id];
        kif.key_valid <= 1'b1;
      end else if (transfer) begin
        kif.key_valid <= 1'b0;
      end
      // A key arriving while the slot is still held is dropped, not queued.
      if (transfer)
        kif.overrun <= 1'b0;
      else if (accept && kif.key_valid)
        kif.overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE=2): a matrix model
// driven from row_out, an expected-code queue and a decoupled output monitor.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] keys;

  int checks   = 0;
  int failures = 0;
  int rises    = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_q[$];

  keypad_if kif ();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .col_in  (col_in),
    .row_out (row_out),
    .kif     (kif)
  );

  always #5 clk = ~clk;

  // Matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row_out[r])
        for (int c = 0; c < 4; c++)
          if (keys[4*r+c]) col_in[c] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every transfer must match the oldest expected code.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && kif.key_valid && !prev_valid) rises++;
    prev_valid = (rst_n === 1'b1) && kif.key_valid;
    if (rst_n === 1'b1 && kif.key_valid && kif.key_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_key: got 0x%0h, expected no transfer", kif.key_code);
      end else begin
        check("key_code", {24'h0, kif.key_code}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int row_edge;
    int valid_edge;
    rst_n         = 1'b0;
    keys          = 16'h0;
    keys[4]       = 1'b1;            // r1c0 held through reset
    kif.key_ready = 1'b1;

    // Reset held 3 cycles with a key pressed.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_row_out", {28'h0, row_out}, 32'hE);
      check("rst_valid", {31'h0, kif.key_valid}, 32'h0);
      check("rst_code", {24'h0, kif.key_code}, 32'h0);
      check("rst_overrun", {31'h0, kif.overrun}, 32'h0);
    end

    // Single press r1c0: edge n after release is cycle n+1 of the scan.
    exp_q.push_back(8'h05);
    rst_n      = 1'b1;
    row_edge   = 0;
    valid_edge = 0;
    for (int n = 1; n <= 60 && valid_edge == 0; n++) begin
      @(posedge clk); #1;
      if (row_edge == 0 && row_out != 4'hE) begin
        row_edge = n;
        check("first_row_change_val", {28'h0, row_out}, 32'hD);
      end
      if (valid_edge == 0 && kif.key_valid) valid_edge = n;
    end
    check("first_row_change_edge", row_edge, 4);
    check("press_latency_edge", valid_edge, 32);
    cycles(160 - 32);
    check("single_press_pulses", rises, 1);
    keys = 16'h0;
    cycles(64);

    // Bounce: r2c2 on alternate frames never settles.
    base = rises;
    for (int i = 0; i < 8; i++) begin
      keys[10] = (i % 2 == 0);
      cycles(16);
    end
    keys = 16'h0;
    cycles(32);
    check("bounce_no_key", rises - base, 0);
    exp_q.push_back(8'h2B);
    keys[10] = 1'b1;
    cycles(64);
    check("bounce_then_stable", rises - base, 1);
    keys = 16'h0;
    cycles(64);

    // Backpressure: second key overruns while 0x07 is still held.
    kif.key_ready = 1'b0;
    exp_q.push_back(8'h07);
    keys[6] = 1'b1;
    cycles(48);
    check("bp_first_valid", {31'h0, kif.key_valid}, 32'h1);
    check("bp_first_code", {24'h0, kif.key_code}, 32'h07);
    check("bp_no_overrun_yet", {31'h0, kif.overrun}, 32'h0);
    keys = 16'h0;
    cycles(64);
    keys[11] = 1'b1;
    cycles(64);
    check("bp_code_kept", {24'h0, kif.key_code}, 32'h07);
    check("bp_overrun", {31'h0, kif.overrun}, 32'h1);
    keys = 16'h0;
    cycles(64);
    kif.key_ready = 1'b1;
    cycles(1);
    kif.key_ready = 1'b0;
    check("bp_valid_cleared", {31'h0, kif.key_valid}, 32'h0);
    check("bp_overrun_cleared", {31'h0, kif.overrun}, 32'h0);
    kif.key_ready = 1'b1;
    cycles(32);

    // Multi-key: r0c0 + r2c3 blocks output until r2c3 lets go.
    base = rises;
    keys[0]  = 1'b1;
    keys[11] = 1'b1;
    cycles(64);
    check("multi_no_key", rises - base, 0);
    exp_q.push_back(8'h01);
    keys[11] = 1'b0;
    cycles(52);
    check("multi_then_single", rises - base, 1);
    keys = 16'h0;
    cycles(64);

    // Reset mid-debounce discards the r3c3 candidate.
    base = rises;
    keys[15] = 1'b1;
    cycles(16);
    rst_n = 1'b0;
    cycles(1);
    check("mid_rst_row_out", {28'h0, row_out}, 32'hE);
    check("mid_rst_valid", {31'h0, kif.key_valid}, 32'h0);
    rst_n    = 1'b1;
    keys     = 16'h0;
    row_edge = 0;
    for (int n = 1; n <= 8 && row_edge == 0; n++) begin
      @(posedge clk); #1;
      if (row_out != 4'hE) row_edge = n;
    end
    check("mid_rst_row_restart", row_edge, 4);
    cycles(80);
    check("mid_rst_no_key", rises - base, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
